// File: rtl/nibble_sum_accumulator.sv
// Accumulates N_SAMPLES 5-bit adder results per window and presents the total on a valid/ready port.
// Optional macro SATURATE_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module nibble_sum_accumulator #(
  parameter  int ACC_W     = 12,
  parameter  int N_SAMPLES = 8,
  localparam int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cout,
  input  logic [3:0]       in_sum,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             accept, win_end, flush;

  // Returns {overflow, new accumulator}; overflow is the carry out of the ACC_W-bit add.
  function automatic logic [ACC_W:0] add_beat(input logic [ACC_W-1:0] a, input logic [4:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-4){1'b0}}, b};
`ifdef SATURATE_EN
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
`endif
    return s;
  endfunction

  assign acc_sum = add_beat(acc, {in_cout, in_sum});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    win_end    = 1'b0;
    flush      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !clear;
        accept   = in_valid && !clear;
        if (clear) begin
          flush = 1'b1;
        end else if (accept && (out_count == LAST)) begin
          win_end    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (clear || out_ready) begin
          flush      = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Window datapath; out_total is only loaded by the beat that closes the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_total <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (flush) begin
      acc       <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      acc       <= acc_sum[ACC_W-1:0];
      out_count <= out_count + CNT_W'(1);
      if (acc_sum[ACC_W]) out_ovf <= 1'b1;
      if (win_end) out_total <= acc_sum[ACC_W-1:0];
    end
  end

endmodule
